// File: rtl/phy_pkg.sv
// Shared definitions for the transmit-side physical layer: K-code
// constants, serializer state encodings, word-size codes and helpers.
package phy_pkg;

   // Comma and filler K-characters as seen by the 8b/10b encoder
   localparam logic [7:0] K28_5 = 8'hBC;
   localparam logic [7:0] K23_7 = 8'hF7;

   // Serializer FSM encodings
   localparam logic [1:0] ST_ELEC_IDLE = 2'd0;
   localparam logic [1:0] ST_FILL      = 2'd1;
   localparam logic [1:0] ST_SEND      = 2'd2;

   // dataS codes: the word carries 2**dataS bytes
   localparam int SZ8  = 0;
   localparam int SZ16 = 1;
   localparam int SZ32 = 2;

   // One serial symbol: the byte plus its K flag
   typedef struct packed {
      logic       k;
      logic [7:0] data;
   } serByte_t;

   // Width of a counter holding 0 .. maxBytes-1, never narrower than one bit
   function automatic int remWidth(input int maxBytes);
      return (maxBytes > 1) ? $clog2(maxBytes) : 1;
   endfunction

endpackage

// File: rtl/ser_shift_reg.sv
// Byte-wide shift register with per-byte K flags. A word is loaded in
// parallel, then shifted down one byte per enabled clock so byte 0 is
// always at the head. rem counts the bytes still to follow the head.
module ser_shift_reg
   import phy_pkg::*;
#(
   parameter int MAX_BYTES = 4,
   parameter int RW        = 2
) (
   input  logic                   clkTx,
   input  logic                   rst,
   input  logic                   load,
   input  logic                   shift,
   input  logic [8*MAX_BYTES-1:0] loadData,
   input  logic [MAX_BYTES-1:0]   loadK,
   input  logic [RW-1:0]          loadRem,
   output logic [7:0]             headByte,
   output logic                   headK,
   output logic [RW-1:0]          rem
);

   logic [8*MAX_BYTES-1:0] dataReg;
   logic [MAX_BYTES-1:0]   kReg;

   // Load a fresh word, or move the next byte to the head and count it off
   always_ff @(posedge clkTx or negedge rst) begin
      if (!rst) begin
         dataReg <= '0;
         kReg    <= '0;
         rem     <= '0;
      end else if (load) begin
         dataReg <= loadData;
         kReg    <= loadK;
         rem     <= loadRem;
      end else if (shift) begin
         dataReg <= dataReg >> 8;
         kReg    <= kReg >> 1;
         rem     <= rem - RW'(1);
      end
   end

   assign headByte = dataReg[7:0];
   assign headK    = kReg[0];

endmodule

// File: rtl/tx_word_serializer.sv
// Transmit word serializer: accepts 1..MAX_BYTES-byte words over a
// valid/ready handshake and emits one byte per clock toward the 8b/10b
// encoder, inserting filler K-characters when idle and honouring
// electrical idle requests at word boundaries.
module tx_word_serializer
   import phy_pkg::*;
#(
   parameter int         MAX_BYTES = 4,
   parameter int         SW        = 2,
   parameter logic [7:0] FILL_BYTE = K23_7
) (
   input  logic                   clkTx,
   input  logic                   rst,
   input  logic                   TxElecIdle,
   input  logic [SW-1:0]          dataS,
   input  logic [8*MAX_BYTES-1:0] dataIn,
   input  logic [MAX_BYTES-1:0]   K,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [7:0]             dataOut,
   output logic                   k_out,
   output logic                   out_valid,
   output logic                   elec_idle_out,
   output logic                   err_width
);

   localparam int RW       = remWidth(MAX_BYTES);
   localparam int MAX_CODE = $clog2(MAX_BYTES);

   logic [1:0]    state;
   logic [1:0]    stateNext;
   logic [RW-1:0] rem;
   logic          remZero;
   logic [7:0]    headByte;
   logic          headK;
   logic          accept;
   logic          legalSize;
   logic          loadWord;
   logic          shiftWord;
   logic [31:0]   wordBytes;
   logic [RW-1:0] loadRem;

   // A word may only be taken when the previous one has its last byte on
   // the line (or nothing is being sent) and no idle is requested.
   assign remZero   = (rem == '0);
   assign in_ready  = !TxElecIdle &&
                      ((state == ST_FILL) || ((state == ST_SEND) && remZero));
   assign accept    = in_valid && in_ready;
   assign legalSize = (32'(dataS) <= 32'(MAX_CODE));
   assign loadWord  = accept && legalSize;
   assign shiftWord = (state == ST_SEND) && !remZero;
   assign wordBytes = 32'd1 << dataS;
   assign loadRem   = RW'(wordBytes - 32'd1);

   ser_shift_reg #(
      .MAX_BYTES (MAX_BYTES),
      .RW        (RW)
   ) uShift (
      .clkTx    (clkTx),
      .rst      (rst),
      .load     (loadWord),
      .shift    (shiftWord),
      .loadData (dataIn),
      .loadK    (K),
      .loadRem  (loadRem),
      .headByte (headByte),
      .headK    (headK),
      .rem      (rem)
   );

   // Next-state decision; idle requests only take effect between words
   always_comb begin
      stateNext = state;
      case (state)
         ST_ELEC_IDLE: begin
            if (!TxElecIdle) stateNext = ST_FILL;
         end
         ST_FILL: begin
            if (loadWord)        stateNext = ST_SEND;
            else if (TxElecIdle) stateNext = ST_ELEC_IDLE;
         end
         ST_SEND: begin
            if (remZero) begin
               if (loadWord)        stateNext = ST_SEND;
               else if (TxElecIdle) stateNext = ST_ELEC_IDLE;
               else                 stateNext = ST_FILL;
            end
         end
         default: stateNext = ST_ELEC_IDLE;
      endcase
   end

   // State register; reset drops straight into electrical idle
   always_ff @(posedge clkTx or negedge rst) begin
      if (!rst) state <= ST_ELEC_IDLE;
      else      state <= stateNext;
   end

   // Flag a dropped word of unsupported width for exactly one cycle
   always_ff @(posedge clkTx or negedge rst) begin
      if (!rst) err_width <= 1'b0;
      else      err_width <= accept && !legalSize;
   end

   // Line outputs are decoded purely from registered state, never from inputs
   always_comb begin
      dataOut = 8'h00;
      k_out   = 1'b0;
      case (state)
         ST_SEND: begin
            dataOut = headByte;
            k_out   = headK;
         end
         ST_FILL: begin
            dataOut = FILL_BYTE;
            k_out   = 1'b1;
         end
         default: begin
            dataOut = 8'h00;
            k_out   = 1'b0;
         end
      endcase
   end

   assign out_valid     = (state == ST_SEND);
   assign elec_idle_out = (state == ST_ELEC_IDLE);

endmodule

// File: tb/tb_tx_word_serializer.sv
// Testbench for tx_word_serializer: directed words with hand-written
// expected byte streams in a scoreboard queue, a monitor popping them
// whenever out_valid is seen, and direct checks of handshake/idle/filler.
module tb_tx_word_serializer;
   import phy_pkg::*;

   logic        clkTx = 1'b0;
   logic        rst = 1'b1;
   logic        TxElecIdle = 1'b1;
   logic [1:0]  dataS = 2'd0;
   logic [31:0] dataIn = 32'h0;
   logic [3:0]  K = 4'h0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  dataOut;
   logic        k_out;
   logic        out_valid;
   logic        elec_idle_out;
   logic        err_width;

   int checks = 0;
   int errors = 0;
   serByte_t expQ[$];

   tx_word_serializer #(
      .MAX_BYTES (4),
      .SW        (2),
      .FILL_BYTE (8'hF7)
   ) dut (
      .clkTx         (clkTx),
      .rst           (rst),
      .TxElecIdle    (TxElecIdle),
      .dataS         (dataS),
      .dataIn        (dataIn),
      .K             (K),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .dataOut       (dataOut),
      .k_out         (k_out),
      .out_valid     (out_valid),
      .elec_idle_out (elec_idle_out),
      .err_width     (err_width)
   );

   // Free-running transmit clock
   always #5 clkTx = ~clkTx;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [1:0] s,
                                input logic [31:0] d, input logic [3:0] kk);
      in_valid = v;
      dataS    = s;
      dataIn   = d;
      K        = kk;
   endtask

   task automatic pushByte(input logic [7:0] d, input logic kk);
      serByte_t e;
      e.data = d;
      e.k    = kk;
      expQ.push_back(e);
   endtask

   task automatic cycle();
      @(posedge clkTx);
      #1;
   endtask

   task automatic checkFill(input string name);
      checkOutput({name, " dataOut"}, 32'(dataOut), 32'h0000_00F7);
      checkOutput({name, " k_out"}, 32'(k_out), 32'd1);
      checkOutput({name, " out_valid"}, 32'(out_valid), 32'd0);
   endtask

   // Monitor: every data byte on the line must match the next expected one
   initial begin
      serByte_t e;
      forever begin
         @(negedge clkTx);
         if (out_valid === 1'b1) begin
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected byte: got %h k=%0d expected none at %0t",
                        dataOut, k_out, $time);
            end else begin
               e = expQ.pop_front();
               checkOutput("stream byte", 32'({k_out, dataOut}), 32'({e.k, e.data}));
            end
         end
      end
   end

   // Watchdog so the run always ends
   initial begin
      #200000;
      checks++;
      errors++;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Directed stimulus
   initial begin
      logic [7:0] n1Bytes [3];
      logic       n1K [3];
      logic       readyExp [4];
      n1Bytes = '{8'h11, 8'h22, 8'h33};
      n1K     = '{1'b0, 1'b1, 1'b0};
      readyExp = '{1'b0, 1'b0, 1'b0, 1'b1};

      // Reset with electrical idle requested
      #2 rst = 1'b0;
      cycle();
      cycle();
      @(negedge clkTx);
      checkOutput("reset dataOut", 32'(dataOut), 32'h0);
      checkOutput("reset k_out", 32'(k_out), 32'd0);
      checkOutput("reset out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset elec_idle_out", 32'(elec_idle_out), 32'd1);
      checkOutput("reset err_width", 32'(err_width), 32'd0);
      checkOutput("reset in_ready", 32'(in_ready), 32'd0);

      // Release reset, stay idle while TxElecIdle=1
      cycle();
      rst = 1'b1;
      cycle();
      @(negedge clkTx);
      checkOutput("idle dataOut", 32'(dataOut), 32'h0);
      checkOutput("idle elec_idle_out", 32'(elec_idle_out), 32'd1);

      // Drop idle request: filler follows on the next edge
      cycle();
      TxElecIdle = 1'b0;
      @(negedge clkTx);
      checkOutput("idle ready", 32'(in_ready), 32'd0);
      cycle();
      @(negedge clkTx);
      checkFill("first fill");
      checkOutput("fill elec_idle_out", 32'(elec_idle_out), 32'd0);
      checkOutput("fill ready", 32'(in_ready), 32'd1);

      // Single byte word
      cycle();
      applyStimulus(1'b1, 2'd0, 32'h0000_00CC, 4'h0);
      pushByte(8'hCC, 1'b0);
      cycle();
      applyStimulus(1'b0, 2'd0, 32'h0, 4'h0);
      cycle();
      @(negedge clkTx);
      checkFill("after 8-bit word");

      // 16-bit word followed back-to-back by a 32-bit word
      cycle();
      applyStimulus(1'b1, 2'd1, 32'h0000_ABCD, 4'h0);
      pushByte(8'hCD, 1'b0);
      pushByte(8'hAB, 1'b0);
      cycle();
      applyStimulus(1'b1, 2'd2, 32'h0123_456F, 4'h0);
      pushByte(8'h6F, 1'b0);
      pushByte(8'h45, 1'b0);
      pushByte(8'h23, 1'b0);
      pushByte(8'h01, 1'b0);
      @(negedge clkTx);
      checkOutput("ready on CD", 32'(in_ready), 32'd0);
      cycle();
      @(negedge clkTx);
      checkOutput("ready on AB", 32'(in_ready), 32'd1);
      cycle();
      applyStimulus(1'b0, 2'd0, 32'h0, 4'h0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clkTx);
         checkOutput("ready in 32-bit word", 32'(in_ready), 32'(readyExp[i]));
         checkOutput("valid in 32-bit word", 32'(out_valid), 32'd1);
         cycle();
      end
      @(negedge clkTx);
      checkFill("after back-to-back");

      // K flags follow their bytes
      cycle();
      applyStimulus(1'b1, 2'd2, 32'hBC00_00BC, 4'b1001);
      pushByte(8'hBC, 1'b1);
      pushByte(8'h00, 1'b0);
      pushByte(8'h00, 1'b0);
      pushByte(8'hBC, 1'b1);
      cycle();
      applyStimulus(1'b0, 2'd0, 32'h0, 4'h0);
      repeat (4) cycle();
      @(negedge clkTx);
      checkFill("after K word");

      // Electrical idle requested mid-word: word completes, then idle
      cycle();
      applyStimulus(1'b1, 2'd2, 32'h0123_456F, 4'h0);
      pushByte(8'h6F, 1'b0);
      pushByte(8'h45, 1'b0);
      pushByte(8'h23, 1'b0);
      pushByte(8'h01, 1'b0);
      cycle();
      applyStimulus(1'b0, 2'd0, 32'h0, 4'h0);
      cycle();
      TxElecIdle = 1'b1;
      @(negedge clkTx);
      checkOutput("idle req ready 45", 32'(in_ready), 32'd0);
      cycle();
      @(negedge clkTx);
      checkOutput("idle req ready 23", 32'(in_ready), 32'd0);
      checkOutput("idle req elec 23", 32'(elec_idle_out), 32'd0);
      cycle();
      @(negedge clkTx);
      checkOutput("idle req ready 01", 32'(in_ready), 32'd0);
      checkOutput("idle req valid 01", 32'(out_valid), 32'd1);
      cycle();
      @(negedge clkTx);
      checkOutput("entered idle elec", 32'(elec_idle_out), 32'd1);
      checkOutput("entered idle dataOut", 32'(dataOut), 32'h0);
      checkOutput("entered idle k_out", 32'(k_out), 32'd0);
      checkOutput("entered idle valid", 32'(out_valid), 32'd0);
      cycle();
      TxElecIdle = 1'b0;
      cycle();
      @(negedge clkTx);
      checkFill("leave idle");

      // Illegal width: accepted, dropped, one-cycle error pulse
      cycle();
      applyStimulus(1'b1, 2'd3, 32'hDEAD_BEEF, 4'hF);
      @(negedge clkTx);
      checkOutput("illegal ready", 32'(in_ready), 32'd1);
      cycle();
      applyStimulus(1'b0, 2'd0, 32'h0, 4'h0);
      @(negedge clkTx);
      checkOutput("err_width pulse", 32'(err_width), 32'd1);
      checkFill("illegal drop");
      cycle();
      @(negedge clkTx);
      checkOutput("err_width clear", 32'(err_width), 32'd0);
      checkFill("after illegal");

      // Single-byte words under continuous traffic keep in_ready high
      for (int i = 0; i < 3; i++) begin
         cycle();
         applyStimulus(1'b1, 2'd0, {24'h0, n1Bytes[i]}, {3'b000, n1K[i]});
         pushByte(n1Bytes[i], n1K[i]);
         @(negedge clkTx);
         checkOutput("n1 ready", 32'(in_ready), 32'd1);
      end
      cycle();
      applyStimulus(1'b0, 2'd0, 32'h0, 4'h0);
      @(negedge clkTx);
      checkOutput("n1 last ready", 32'(in_ready), 32'd1);
      cycle();
      @(negedge clkTx);
      checkFill("after n1 stream");

      // Reset mid-word: outputs return to reset values at once
      cycle();
      applyStimulus(1'b1, 2'd2, 32'hAABB_CCDD, 4'h0);
      pushByte(8'hDD, 1'b0);
      pushByte(8'hCC, 1'b0);
      cycle();
      applyStimulus(1'b0, 2'd0, 32'h0, 4'h0);
      cycle();
      @(negedge clkTx);
      #1 rst = 1'b0;
      #1;
      checkOutput("mid reset dataOut", 32'(dataOut), 32'h0);
      checkOutput("mid reset k_out", 32'(k_out), 32'd0);
      checkOutput("mid reset out_valid", 32'(out_valid), 32'd0);
      checkOutput("mid reset elec", 32'(elec_idle_out), 32'd1);
      checkOutput("mid reset ready", 32'(in_ready), 32'd0);
      cycle();
      rst = 1'b1;
      @(negedge clkTx);
      checkOutput("post reset elec", 32'(elec_idle_out), 32'd1);
      cycle();
      @(negedge clkTx);
      checkFill("post reset fill");
      repeat (3) cycle();

      checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tx_word_serializer.md
Name: tx_word_serializer

Overview:
- Parametrised transmit-side byte serializer for the PCIe-style physical layer.
- Accepts words of 1, 2, 4 … MAX_BYTES bytes, selected per word by dataS, with per-byte K flags. Emits one byte per clock, with its K flag, toward the 8b/10b encoder.
- Inserts filler K-characters when no data is pending and supports electrical idle (TxElecIdle).
- Successor to the fixed 8/16/32 striping path: generalised width, valid/ready handshake, back-to-back words.

Parameters:
- MAX_BYTES, 4: maximum word width in bytes; power of 2, ≥1.
- SW, 2: width of dataS; 2**SW must exceed log2(MAX_BYTES).
- FILL_BYTE, 8'hF7: filler byte (K23.7), emitted with k_out=1.

Ports:
- clkTx  input  1  single clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- TxElecIdle  input  1  request electrical idle.
- dataS  input  SW  word size code; word is 2**dataS bytes.
- dataIn  input  8*MAX_BYTES  word; byte i = dataIn[8i+7:8i].
- K  input  MAX_BYTES  per-byte K flag.
- in_valid  input  1  word present.
- in_ready  output  1  word accepted on edge where in_valid&&in_ready.
- dataOut  output  8  serial byte, registered.
- k_out  output  1  K flag of dataOut.
- out_valid  output  1  dataOut carries a data byte (not filler, not idle).
- elec_idle_out  output  1  transmitter in electrical idle.
- err_width  output  1  one-cycle pulse: word with illegal dataS was dropped.

Behaviour:
- Reset (rst=0, async):
  - Outputs: dataOut=0, k_out=0, out_valid=0, elec_idle_out=1, err_width=0, in_ready=0.
  - State=ELEC_IDLE; shift register and byte counter cleared.
- States:
  - ELEC_IDLE: dataOut=0, k_out=0, elec_idle_out=1. Goes to FILL on the first edge with TxElecIdle=0. in_ready=0 throughout.
  - FILL: dataOut=FILL_BYTE, k_out=1, out_valid=0.
  - SEND: emits latched bytes LSB first.
- in_ready is combinational: 1 when TxElecIdle=0 and either state==FILL, or state==SEND with rem==0 (last byte currently on dataOut).
- Acceptance at edge t (legal dataS):
  - Latch the word, K and width N=2**dataS.
  - From edge t, dataOut=byte0, k_out=K[0], out_valid=1; rem=N-1.
  - Each later edge shifts to the next byte and decrements rem.
  - Latency from acceptance to first byte: 1 clock.
- Back-to-back: a word accepted while rem==0 puts its byte0 out on the next edge. No gap, no filler.
- End of word with rem==0 and no acceptance:
  - TxElecIdle=0: next edge goes to FILL.
  - TxElecIdle=1: next edge goes to ELEC_IDLE.
- TxElecIdle mid-word: the current word completes (all N bytes sent). Idle is entered on the edge after the last byte; in_ready stays 0 meanwhile.
- dataS and K are sampled only at acceptance; changes mid-word have no effect.
- N=1: every word occupies 1 cycle; in_ready stays 1 under continuous traffic.
- Illegal dataS (2**dataS > MAX_BYTES):
  - The word is still accepted (handshake completes) and then discarded.
  - err_width=1 for the next cycle.
  - Output continues exactly as if no word had been accepted: FILL, or ELEC_IDLE if TxElecIdle=1.
- Reset mid-word: the word is lost. Outputs return to reset values immediately; no partial bytes after release.

Decomposition:
- Shared package (phy_pkg): FILL/COM K-code constants (K28.5 8'hBC, K23.7 8'hF7), state encodings, dataS encodings (SZ8=0, SZ16=1, SZ32=2).
- Sub-module ser_shift_reg: MAX_BYTES-wide byte+K shift register with parallel load, shift enable and rem counter.
- Top level holds the FSM, handshake and error logic.

Test Plan:
- Reset held, then released with TxElecIdle=1 → dataOut=0, elec_idle_out=1. Drop TxElecIdle → next edge dataOut=8'hF7, k_out=1, out_valid=0.
- dataS=0, dataIn8=8'hCC, K=0 → one byte 8'hCC with out_valid=1, then filler.
- dataS=1, 16'hABCD, then immediately dataS=2, 32'h0123456F → CD, AB, 6F, 45, 23, 01 on 6 consecutive cycles. in_ready high only on the AB cycle and the 01 cycle.
- 32-bit word 32'hBC00_00BC with K=4'b1001 → k_out sequence 1, 0, 0, 1.
- TxElecIdle raised on the second byte of 32'h0123456F → bytes 23 and 01 still emitted, then elec_idle_out=1, dataOut=0; in_ready=0 throughout.
- dataS=3 with MAX_BYTES=4 → word accepted, err_width pulses one cycle, output stays F7 filler. Separately, rst pulled low mid-word → all outputs at reset values in the same cycle.
